// File: rtl/key_matrix_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package key_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_e;

  // Key-code assignments consumed by the clock control logic.
  localparam logic [3:0] HU   = 4'd0;
  localparam logic [3:0] HD   = 4'd1;
  localparam logic [3:0] MU   = 4'd2;
  localparam logic [3:0] MD   = 4'd3;
  localparam logic [3:0] SU   = 4'd4;
  localparam logic [3:0] SD   = 4'd5;
  localparam logic [3:0] SET  = 4'd6;
  localparam logic [3:0] END  = 4'd7;
  localparam logic [3:0] MENU = 4'd8;

  // Lowest-index active-low column wins.
  function automatic logic [1:0] first_low(input logic [NUM_COLS-1:0] col);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (!col[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_matrix_scanner_scan_tick_gen.sv
// Free-running row-dwell divider; tick strobes on the last count of each dwell.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic CP,
  input  logic CR,
  output logic tick
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) div_q <= '0;
    else    div_q <= div_d;
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x4 keypad scanner with debounce; one KEY_VALID per press.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a key stays down.
module key_matrix_scanner
  import key_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 100,
  parameter int unsigned REPEAT_PERIOD  = 25
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [3:0] COL_IN,
  output logic [3:0] ROW_OUT,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic             tick;
  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       col_s_q, col_s_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             cand_low, accept;

`ifdef KEY_REPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc, hold_lim;
  logic              rep_phase_q, rep_phase_d;
`endif

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .CP  (CP),
    .CR  (CR),
    .tick(tick)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cand_col_d  = cand_col_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    sync1_d     = COL_IN;
    col_s_d     = sync1_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    cand_low    = ~col_s_q[cand_col_q];
`ifdef KEY_REPEAT_EN
    hold_d      = hold_q;
    rep_phase_d = rep_phase_q;
    hold_inc    = hold_q + 1'b1;
    hold_lim    = rep_phase_q ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY);
`endif

    unique case (state_q)
      SCAN: if (tick) begin
        if (col_s_q != '1) begin
          cand_col_d = first_low(col_s_q);
          cnt_d      = CNT_W'(1);
          if (cnt_d == CNT_MAX) accept = 1'b1;
          else                  state_d = DEBOUNCE;
        end else begin
          row_d = row_q + 2'd1;
        end
      end
      DEBOUNCE: if (tick) begin
        if (cand_low) begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) accept = 1'b1;
        end else begin
          cnt_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = SCAN;
        end
      end
      PRESSED: if (tick) begin
        if (!cand_low) begin
          rel_d = (rel_q == CNT_MAX) ? CNT_MAX : rel_q + 1'b1;
`ifdef KEY_REPEAT_EN
          hold_d      = '0;
          rep_phase_d = 1'b0;
`endif
          if (rel_d == CNT_MAX) begin
            rel_d      = '0;
            key_held_d = 1'b0;
            row_d      = row_q + 2'd1;
            state_d    = SCAN;
          end
        end else begin
          rel_d = '0;
`ifdef KEY_REPEAT_EN
          // First repeat after REPEAT_DELAY ticks, then every REPEAT_PERIOD.
          if (hold_inc == hold_lim) begin
            key_valid_d = 1'b1;
            hold_d      = '0;
            rep_phase_d = 1'b1;
          end else begin
            hold_d = hold_inc;
          end
`endif
        end
      end
      default: state_d = SCAN;
    endcase

    if (accept) begin
      key_code_d  = {row_q, cand_col_d};
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      cnt_d       = '0;
      rel_d       = '0;
      state_d     = PRESSED;
`ifdef KEY_REPEAT_EN
      hold_d      = '0;
      rep_phase_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q     <= SCAN;
      row_q       <= '0;
      cand_col_q  <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      sync1_q     <= '1;
      col_s_q     <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      hold_q      <= '0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      sync1_q     <= sync1_d;
      col_s_q     <= col_s_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
      hold_q      <= hold_d;
      rep_phase_q <= rep_phase_d;
`endif
    end
  end

  assign ROW_OUT   = ~(4'b0001 << row_q);
  assign KEY_CODE  = key_code_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_HELD  = key_held_q;

endmodule
